// File: rtl/pixel_plot_sink_pkg.sv
`default_nettype none
// ============================================================================
// pixel_plot_sink_pkg : frame geometry, request layout and address helpers
// Revision: 1.0
// ============================================================================
package pixel_plot_sink_pkg;

  localparam int H_PIX      = 160;
  localparam int V_PIX      = 120;
  localparam int AW         = 15;
  localparam int CW         = 3;
  localparam int XW         = 8;
  localparam int YW         = 7;
  localparam int FRAME_SIZE = H_PIX * V_PIX;
  localparam int ENTRY_W    = XW + YW + CW;

  localparam logic [AW-1:0] FRAME_LAST = AW'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAIN_CLR = 2'd1,
    ST_CLEAR     = 2'd2
  } state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
  } plot_req_t;

  // Both operands are below V_PIX, so one conditional subtract wraps the sum.
  function automatic logic [YW-1:0] scroll_y(input logic [YW-1:0] y, input logic [YW-1:0] off);
    logic [YW:0] s;
    s = {1'b0, y} + {1'b0, off};
    if (s >= (YW+1)'(V_PIX)) s = s - (YW+1)'(V_PIX);
    return s[YW-1:0];
  endfunction

  // y*160 + x as y*128 + y*32 + x.
  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_plot_sink_fifo.sv
`default_nettype none
// ============================================================================
// pixel_plot_sink_fifo : synchronous FIFO holding clipped plot requests
// Revision: 1.0
// ============================================================================
module pixel_plot_sink_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/pixel_plot_sink.sv
`default_nettype none
// ============================================================================
// pixel_plot_sink : buffers/clips/scrolls plot requests into framebuffer writes,
//                   plus a full-frame clear sweep
// Revision: 1.0
// ============================================================================
module pixel_plot_sink
  import pixel_plot_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] i_plot_x,
  input  logic [YW-1:0] i_plot_y,
  input  logic [CW-1:0] i_plot_colour,
  input  logic          i_plot,
  output logic          o_plot_ready,
  input  logic          i_clear_req,
  input  logic [CW-1:0] i_clear_colour,
  input  logic          i_scroll_en,
  input  logic          i_vsync_tick,
  input  logic          i_fb_wait,
  output logic          o_fb_we,
  output logic [AW-1:0] o_fb_addr,
  output logic [CW-1:0] o_fb_data,
  output logic          o_busy,
  output logic [7:0]    o_drop_count
);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_clear_pending;
  logic [CW-1:0]               r_clear_colour;
  logic [YW-1:0]               r_scroll_off;
  logic [AW-1:0]               r_sweep_cnt;
  logic [7:0]                  r_drop_count;
  logic                        r_fb_we;
  logic [AW-1:0]               r_fb_addr;
  logic [CW-1:0]               r_fb_data;

  logic                        w_in_range;
  logic                        w_accept;
  logic                        w_push;
  logic                        w_drop;
  logic                        w_pop;
  logic                        w_sweep_wr;
  logic                        w_sweep_last;
  plot_req_t                   w_req;
  plot_req_t                   w_head;
  logic [ENTRY_W-1:0]          w_head_raw;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic [YW-1:0]               w_y_eff;

  assign w_in_range   = (i_plot_x < XW'(H_PIX)) && (i_plot_y < YW'(V_PIX));
  assign o_plot_ready = !rst && (r_state == ST_IDLE) && !r_clear_pending && !w_fifo_full;
  assign w_accept     = i_plot && o_plot_ready;
  assign w_push       = w_accept && w_in_range;
  assign w_drop       = w_accept && !w_in_range;
  assign w_req        = '{x: i_plot_x, y: i_plot_y, colour: i_plot_colour};
  assign w_head       = plot_req_t'(w_head_raw);
  assign w_y_eff      = scroll_y(w_head.y, r_scroll_off);

  pixel_plot_sink_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_plot_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_data  (w_head_raw),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_sweep_wr   = 1'b0;
    w_sweep_last = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pop = !w_fifo_empty && !i_fb_wait;
        if (r_clear_pending) w_state_nxt = ST_DRAIN_CLR;
      end
      ST_DRAIN_CLR: begin
        w_pop = !w_fifo_empty && !i_fb_wait;
        if (w_fifo_empty) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!i_fb_wait) begin
          w_sweep_wr = 1'b1;
          if (r_sweep_cnt == FRAME_LAST) begin
            w_sweep_last = 1'b1;
            w_state_nxt  = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clear_pending <= 1'b0;
      r_clear_colour  <= '0;
      r_scroll_off    <= '0;
      r_sweep_cnt     <= '0;
      r_drop_count    <= '0;
      r_fb_we         <= 1'b0;
      r_fb_addr       <= '0;
      r_fb_data       <= '0;
    end else begin
      r_fb_we <= 1'b0;
      if (w_pop) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= pix_addr(w_head.x, w_y_eff);
        r_fb_data <= w_head.colour;
      end else if (w_sweep_wr) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= r_sweep_cnt;
        r_fb_data <= r_clear_colour;
      end

      // Counter parks at zero outside the sweep so CLEAR always starts at pixel 0.
      if (r_state != ST_CLEAR) r_sweep_cnt <= '0;
      else if (w_sweep_wr)     r_sweep_cnt <= r_sweep_cnt + 1'b1;

      if (i_clear_req && (r_state != ST_CLEAR)) begin
        r_clear_pending <= 1'b1;
        r_clear_colour  <= i_clear_colour;
      end else if (w_sweep_last) begin
        r_clear_pending <= 1'b0;
      end

      if (i_vsync_tick && i_scroll_en)
        r_scroll_off <= (r_scroll_off == YW'(V_PIX - 1)) ? '0 : r_scroll_off + 1'b1;

      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign o_fb_we      = r_fb_we;
  assign o_fb_addr    = r_fb_addr;
  assign o_fb_data    = r_fb_data;
  assign o_busy       = r_clear_pending || (r_state != ST_IDLE);
  assign o_drop_count = r_drop_count;

endmodule
`default_nettype wire
